// File: rtl/bp_common_pkg.sv
// Shared types and constants for the softcore memory scheduler:
// destination enum, scheduler FSM states, device group IDs and the
// address-to-destination decode helper.
package bp_common_pkg;

    typedef enum logic [1:0] {
        DEST_MEM   = 2'd0,
        DEST_IO    = 2'd1,
        DEST_CLINT = 2'd2
    } bp_mem_dest_e;

    typedef enum logic {
        SCHED_IDLE = 1'b0,
        SCHED_HOLD = 1'b1
    } bp_mem_sched_state_e;

    localparam logic [3:0] host_dev_gp  = 4'd1;
    localparam logic [3:0] clint_dev_gp = 4'd3;

    // DRAM space wins outright; below it the device field picks io/clint,
    // and any unknown device falls back to mem.
    function automatic bp_mem_dest_e bp_decode_dest(input logic is_dram, input logic [3:0] dev);
        if (is_dram)                  return DEST_MEM;
        else if (dev == host_dev_gp)  return DEST_IO;
        else if (dev == clint_dev_gp) return DEST_CLINT;
        else                          return DEST_MEM;
    endfunction

endpackage

// File: rtl/bp_mem_sched_arb.sv
// Single-grant arbiter for the memory scheduler.
// Default build: fixed priority, highest index wins, stateless.
// With BP_MEM_SCHED_RR_EN defined: round-robin starting at a pointer that
// moves to winner+1 after each grant.
module bp_mem_sched_arb #(
    parameter int reqs_p     = 2,
    parameter int id_width_p = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  en_i,
    input  logic [reqs_p-1:0]     req_i,
    output logic [reqs_p-1:0]     grant_o,
    output logic [id_width_p-1:0] grant_id_o,
    output logic                  grant_v_o
);

`ifdef BP_MEM_SCHED_RR_EN
    logic [id_width_p-1:0] ptr_q, ptr_d;
    int                    idx;

    // Scan from the pointer upward; the first requester found wins.
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        grant_v_o  = 1'b0;
        ptr_d      = ptr_q;
        idx        = 0;
        if (en_i) begin
            for (int k = reqs_p - 1; k >= 0; k--) begin
                idx = (int'(ptr_q) + k) % reqs_p;
                if (req_i[idx]) begin
                    grant_id_o = id_width_p'(idx);
                    grant_v_o  = 1'b1;
                end
            end
        end
        if (grant_v_o) begin
            grant_o[grant_id_o] = 1'b1;
            ptr_d = id_width_p'((int'(grant_id_o) + 1) % reqs_p);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ reset_n_i;

    // Fixed priority: ascending scan, so the highest requesting index wins.
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        grant_v_o  = 1'b0;
        if (en_i) begin
            for (int k = 0; k < reqs_p; k++) begin
                if (req_i[k]) begin
                    grant_id_o = id_width_p'(k);
                    grant_v_o  = 1'b1;
                end
            end
        end
        if (grant_v_o) grant_o[grant_id_o] = 1'b1;
    end
`endif

endmodule

// File: rtl/bp_softcore_mem_sched.sv
// Memory scheduler for the softcore: arbitrates per-requester commands
// into a single held output register routed to mem/io/clint, routes
// responses back by ID (clint > io > mem), and tracks outstanding credits.
// Optional: BP_MEM_SCHED_RR_EN selects round-robin arbitration.
// Handshakes: a command is taken when cmd_v_i & cmd_yumi_o; a downstream
// command moves when _cmd_v_o & _ready_i; a response moves when its
// resp_v_o & resp_yumi_i, and the winning source sees that yumi.
module bp_softcore_mem_sched
    import bp_common_pkg::*;
#(
    parameter int reqs_p        = 2,
    parameter int msg_width_p   = 512,
    parameter int paddr_width_p = 40,
    parameter int id_width_p    = 1,
    parameter int max_out_p     = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [reqs_p*msg_width_p-1:0]   cmd_i,
    input  logic [reqs_p*paddr_width_p-1:0] cmd_addr_i,
    input  logic [reqs_p-1:0]               cmd_v_i,
    output logic [reqs_p-1:0]               cmd_yumi_o,
    output logic [msg_width_p-1:0]          mem_cmd_o,
    output logic [msg_width_p-1:0]          io_cmd_o,
    output logic [msg_width_p-1:0]          clint_cmd_o,
    output logic                            mem_cmd_v_o,
    output logic                            io_cmd_v_o,
    output logic                            clint_cmd_v_o,
    input  logic                            mem_cmd_ready_i,
    input  logic                            io_cmd_ready_i,
    input  logic                            clint_cmd_ready_i,
    input  logic [msg_width_p-1:0]          mem_resp_i,
    input  logic [msg_width_p-1:0]          io_resp_i,
    input  logic [msg_width_p-1:0]          clint_resp_i,
    input  logic [id_width_p-1:0]           mem_resp_id_i,
    input  logic [id_width_p-1:0]           io_resp_id_i,
    input  logic [id_width_p-1:0]           clint_resp_id_i,
    input  logic                            mem_resp_v_i,
    input  logic                            io_resp_v_i,
    input  logic                            clint_resp_v_i,
    output logic                            mem_resp_yumi_o,
    output logic                            io_resp_yumi_o,
    output logic                            clint_resp_yumi_o,
    output logic [reqs_p*msg_width_p-1:0]   resp_o,
    output logic [reqs_p-1:0]               resp_v_o,
    input  logic [reqs_p-1:0]               resp_yumi_i,
    output logic [reqs_p-1:0]               credits_full_o,
    output logic [reqs_p-1:0]               credits_empty_o,
    output bp_mem_sched_state_e             state_o
);

    localparam int cnt_width_lp = $clog2(max_out_p + 1);

    bp_mem_sched_state_e       state_q, state_d;
    logic [msg_width_p-1:0]    msg_q, msg_d;
    bp_mem_dest_e              dest_q, dest_d;
    logic [cnt_width_lp-1:0]   cnt_q [reqs_p];
    logic [cnt_width_lp-1:0]   cnt_d [reqs_p];
    logic [reqs_p-1:0]         at_max, dec;
    logic [reqs_p-1:0]         grant;
    logic [id_width_p-1:0]     grant_id;
    logic                      grant_v, arb_en, hold_v, dest_ready;
    logic [paddr_width_p-1:0]  grant_addr;

    assign state_o = state_q;
    assign arb_en  = reset_n_i && (state_q == SCHED_IDLE);

    // Credit status; reset forces the "empty, not full" view.
    always_comb begin
        at_max          = '0;
        credits_full_o  = '0;
        credits_empty_o = '1;
        for (int r = 0; r < reqs_p; r++) begin
            at_max[r]          = (cnt_q[r] == cnt_width_lp'(max_out_p));
            credits_full_o[r]  = reset_n_i && at_max[r];
            credits_empty_o[r] = !reset_n_i || (cnt_q[r] == '0);
        end
    end

    bp_mem_sched_arb #(
        .reqs_p     (reqs_p),
        .id_width_p (id_width_p)
    ) arb (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .en_i       (arb_en),
        .req_i      (cmd_v_i & ~at_max),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .grant_v_o  (grant_v)
    );

    // Scheduler FSM: capture a granted command in IDLE, hold it until the
    // chosen destination accepts.
    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        dest_d     = dest_q;
        cmd_yumi_o = '0;
        grant_addr = cmd_addr_i[int'(grant_id)*paddr_width_p +: paddr_width_p];
        unique case (dest_q)
            DEST_IO:    dest_ready = io_cmd_ready_i;
            DEST_CLINT: dest_ready = clint_cmd_ready_i;
            default:    dest_ready = mem_cmd_ready_i;
        endcase
        unique case (state_q)
            SCHED_IDLE: begin
                if (grant_v) begin
                    cmd_yumi_o = grant;
                    msg_d      = cmd_i[int'(grant_id)*msg_width_p +: msg_width_p];
                    dest_d     = bp_decode_dest(64'(grant_addr) >= 64'h8000_0000,
                                                grant_addr[23:20]);
                    state_d    = SCHED_HOLD;
                end
            end
            SCHED_HOLD: begin
                if (dest_ready) state_d = SCHED_IDLE;
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    assign hold_v        = reset_n_i && (state_q == SCHED_HOLD);
    assign mem_cmd_v_o   = hold_v && (dest_q == DEST_MEM);
    assign io_cmd_v_o    = hold_v && (dest_q == DEST_IO);
    assign clint_cmd_v_o = hold_v && (dest_q == DEST_CLINT);
    assign mem_cmd_o     = msg_q;
    assign io_cmd_o      = msg_q;
    assign clint_cmd_o   = msg_q;

    // Response routing: per requester, clint beats io beats mem; the winner
    // forwards that requester's yumi, losers see zero.
    always_comb begin
        resp_o            = '0;
        resp_v_o          = '0;
        dec               = '0;
        mem_resp_yumi_o   = 1'b0;
        io_resp_yumi_o    = 1'b0;
        clint_resp_yumi_o = 1'b0;
        if (reset_n_i) begin
            for (int r = 0; r < reqs_p; r++) begin
                if (clint_resp_v_i && clint_resp_id_i == id_width_p'(r)) begin
                    resp_o[r*msg_width_p +: msg_width_p] = clint_resp_i;
                    resp_v_o[r]       = 1'b1;
                    clint_resp_yumi_o = resp_yumi_i[r];
                end else if (io_resp_v_i && io_resp_id_i == id_width_p'(r)) begin
                    resp_o[r*msg_width_p +: msg_width_p] = io_resp_i;
                    resp_v_o[r]    = 1'b1;
                    io_resp_yumi_o = resp_yumi_i[r];
                end else if (mem_resp_v_i && mem_resp_id_i == id_width_p'(r)) begin
                    resp_o[r*msg_width_p +: msg_width_p] = mem_resp_i;
                    resp_v_o[r]     = 1'b1;
                    mem_resp_yumi_o = resp_yumi_i[r];
                end
                dec[r] = resp_v_o[r] && resp_yumi_i[r];
            end
        end
    end

    // Outstanding counters: grant increments, consumed response decrements,
    // both together cancel; a decrement at zero is ignored.
    always_comb begin
        for (int r = 0; r < reqs_p; r++) begin
            cnt_d[r] = cnt_q[r];
            if (cmd_yumi_o[r] && !dec[r])
                cnt_d[r] = cnt_q[r] + cnt_width_lp'(1);
            else if (!cmd_yumi_o[r] && dec[r] && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - cnt_width_lp'(1);
        end
    end

    // State, held command and counters.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= SCHED_IDLE;
            msg_q   <= '0;
            dest_q  <= DEST_MEM;
            for (int r = 0; r < reqs_p; r++) cnt_q[r] <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            dest_q  <= dest_d;
            for (int r = 0; r < reqs_p; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    for (genvar r = 0; r < reqs_p; r++) begin : g_underflow_chk
        a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
            !(dec[r] && cnt_q[r] == '0));
    end

endmodule

// File: tb/tb_bp_softcore_mem_sched.sv
// Randomized bench for bp_softcore_mem_sched with a transaction-level
// reference model (outstanding counts, one held command, per-requester
// response priority). Honors BP_MEM_SCHED_RR_EN like the design.
module tb_bp_softcore_mem_sched;
    import bp_common_pkg::*;

    localparam int MW  = 64;
    localparam int AW  = 40;
    localparam int MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [MW-1:0]    cmsg [2];
    logic [AW-1:0]    caddr [2];
    logic [1:0]       cmd_v;
    logic [1:0]       cmd_yumi;
    logic [MW-1:0]    cmd_o [3];
    logic             cmd_vo [3];
    logic             sready [3];
    logic [MW-1:0]    sdata [3];
    logic             sid [3];
    logic             sv [3];
    logic             syumi [3];
    logic [2*MW-1:0]  resp;
    logic [1:0]       resp_v;
    logic [1:0]       resp_yumi;
    logic [1:0]       full, empty;
    bp_mem_sched_state_e st;

    bp_softcore_mem_sched #(
        .reqs_p(2), .msg_width_p(MW), .paddr_width_p(AW), .id_width_p(1), .max_out_p(MAX)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .cmd_i({cmsg[1], cmsg[0]}), .cmd_addr_i({caddr[1], caddr[0]}),
        .cmd_v_i(cmd_v), .cmd_yumi_o(cmd_yumi),
        .mem_cmd_o(cmd_o[0]), .io_cmd_o(cmd_o[1]), .clint_cmd_o(cmd_o[2]),
        .mem_cmd_v_o(cmd_vo[0]), .io_cmd_v_o(cmd_vo[1]), .clint_cmd_v_o(cmd_vo[2]),
        .mem_cmd_ready_i(sready[0]), .io_cmd_ready_i(sready[1]), .clint_cmd_ready_i(sready[2]),
        .mem_resp_i(sdata[0]), .io_resp_i(sdata[1]), .clint_resp_i(sdata[2]),
        .mem_resp_id_i(sid[0]), .io_resp_id_i(sid[1]), .clint_resp_id_i(sid[2]),
        .mem_resp_v_i(sv[0]), .io_resp_v_i(sv[1]), .clint_resp_v_i(sv[2]),
        .mem_resp_yumi_o(syumi[0]), .io_resp_yumi_o(syumi[1]), .clint_resp_yumi_o(syumi[2]),
        .resp_o(resp), .resp_v_o(resp_v), .resp_yumi_i(resp_yumi),
        .credits_full_o(full), .credits_empty_o(empty), .state_o(st)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: outstanding per requester, one held command.
    int          m_cnt [2];
    bit          m_hold;
    logic [MW-1:0] m_msg;
    int          m_dest;   // 0 mem, 1 io, 2 clint
    int          m_ptr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40) $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dest_of(input logic [AW-1:0] a);
        if (a >= 40'h00_8000_0000) return 0;
        if (a[23:20] == 4'd1)      return 1;
        if (a[23:20] == 4'd3)      return 2;
        return 0;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        int k;
        a = {8'($urandom), 32'($urandom)};
        k = $urandom_range(0, 3);
        if (k != 0) begin
            a[39:31] = '0;
            if (k == 1)      a[23:20] = 4'd1;
            else if (k == 2) a[23:20] = 4'd3;
            else             a[23:20] = 4'($urandom_range(4, 15));
        end
        return a;
    endfunction

    // Compare this cycle's outputs with the model, then advance the model.
    task automatic model_cycle();
        logic [1:0] e_yumi, e_rv, e_full, e_empty, dec;
        logic [2:0] e_cv, e_syumi;
        logic [MW-1:0] e_resp [2];
        int g;
        e_yumi = '0; e_rv = '0; e_full = '0; e_empty = 2'b11;
        e_cv = '0; e_syumi = '0; dec = '0; g = -1;
        e_resp[0] = '0; e_resp[1] = '0;
        if (rst_n) begin
            for (int r = 0; r < 2; r++) begin
                e_full[r]  = (m_cnt[r] == MAX);
                e_empty[r] = (m_cnt[r] == 0);
            end
            if (!m_hold) begin
`ifdef BP_MEM_SCHED_RR_EN
                for (int k = 1; k >= 0; k--) begin
                    int idx;
                    idx = (m_ptr + k) % 2;
                    if (cmd_v[idx] && m_cnt[idx] < MAX) g = idx;
                end
`else
                for (int r = 0; r < 2; r++)
                    if (cmd_v[r] && m_cnt[r] < MAX) g = r;
`endif
                if (g >= 0) e_yumi[g] = 1'b1;
            end else begin
                e_cv[m_dest] = 1'b1;
            end
            for (int r = 0; r < 2; r++) begin
                for (int s = 2; s >= 0; s--) begin
                    if (!e_rv[r] && sv[s] && int'(sid[s]) == r) begin
                        e_rv[r]    = 1'b1;
                        e_resp[r]  = sdata[s];
                        e_syumi[s] = resp_yumi[r];
                    end
                end
                dec[r] = e_rv[r] & resp_yumi[r];
            end
            check("state_hold", 64'(st == SCHED_HOLD), 64'(m_hold));
        end
        check("cmd_yumi", 64'(cmd_yumi), 64'(e_yumi));
        check("cmd_v", 64'({cmd_vo[2], cmd_vo[1], cmd_vo[0]}), 64'(e_cv));
        if (rst_n && m_hold) check("cmd_msg", cmd_o[m_dest], m_msg);
        check("resp_v", 64'(resp_v), 64'(e_rv));
        for (int r = 0; r < 2; r++)
            if (e_rv[r]) check("resp_data", resp[r*MW +: MW], e_resp[r]);
        check("src_yumi", 64'({syumi[2], syumi[1], syumi[0]}), 64'(e_syumi));
        check("credits_full", 64'(full), 64'(e_full));
        check("credits_empty", 64'(empty), 64'(e_empty));

        if (!rst_n) begin
            m_hold = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0; m_ptr = 0;
        end else begin
            if (m_hold) begin
                if (sready[m_dest]) m_hold = 1'b0;
            end else if (g >= 0) begin
                m_hold = 1'b1;
                m_msg  = cmsg[g];
                m_dest = dest_of(caddr[g]);
                m_ptr  = (g + 1) % 2;
            end
            for (int r = 0; r < 2; r++)
                m_cnt[r] = m_cnt[r] + ((g == r) ? 1 : 0) - (dec[r] ? 1 : 0);
        end
    endtask

    initial begin
        int resp_pct, rdy_pct;
        m_cnt[0] = 0; m_cnt[1] = 0; m_hold = 1'b0; m_msg = '0; m_dest = 0; m_ptr = 0;
        rst_n = 1'b0; cmd_v = '0; resp_yumi = '0;
        for (int i = 0; i < 2; i++) begin cmsg[i] = '0; caddr[i] = '0; end
        for (int s = 0; s < 3; s++) begin
            sready[s] = 1'b0; sdata[s] = '0; sid[s] = 1'b0; sv[s] = 1'b0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            // Phases: mixed, starved responses (fills credits), slow ready
            // (long holds), fast drain.
            case ((cyc / 500) % 4)
                0:       begin resp_pct = 40; rdy_pct = 60; end
                1:       begin resp_pct = 4;  rdy_pct = 70; end
                2:       begin resp_pct = 30; rdy_pct = 10; end
                default: begin resp_pct = 70; rdy_pct = 90; end
            endcase
            rst_n = (cyc < 3) ? 1'b0 : ($urandom_range(0, 299) != 0);
            for (int i = 0; i < 2; i++) begin
                cmd_v[i] = ($urandom_range(0, 99) < 70);
                cmsg[i]  = {$urandom, $urandom};
                caddr[i] = rand_addr();
            end
            for (int s = 0; s < 3; s++) begin
                sready[s] = ($urandom_range(0, 99) < rdy_pct);
                sdata[s]  = {$urandom, $urandom};
                sid[s]    = 1'($urandom_range(0, 1));
                sv[s]     = ($urandom_range(0, 99) < resp_pct) && (m_cnt[sid[s]] > 0);
            end
            for (int r = 0; r < 2; r++) resp_yumi[r] = ($urandom_range(0, 99) < 70);
            #1;
            model_cycle();
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
